minized_gpio_inputs: RTL and testbench

PL-side input conditioner feeding the Zynq PS GPIO EMIO input bus, so software can read PL pushbuttons and switches through the GPIO controller. Each asynchronous pin is synchronized and debounced, and drives a level bit. Sticky rising-edge and falling-edge event flags are latched alongside each level bit. Software clears the flags through edge-triggered request bits on the EMIO output bus. The block sits in the top level between the board input pins and the `system` block's `GPIO_tri_i`/`GPIO_tri_o` ports.

---
 rtl/minized_gpio_pkg.sv | 12 +
 rtl/minized_gpio_inputs_debounce.sv | 54 +++++
 rtl/minized_gpio_inputs.sv | 67 ++++++
 tb/tb_minized_gpio_inputs.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/minized_gpio_pkg.sv
// Shared field layout and identification constants for the GPIO EMIO input conditioner.
package minized_gpio_pkg;

    localparam int unsigned LEVEL_LSB   = 0;
    localparam int unsigned RISE_LSB    = 4;
    localparam int unsigned FALL_LSB    = 8;
    localparam int unsigned VERSION_LSB = 12;
    localparam int unsigned MAX_WIDTH   = 4;

    localparam logic [3:0] VERSION = 4'hA;

endpackage

// File: rtl/minized_gpio_inputs_debounce.sv
// Single-pin conditioner: 2-flop synchronizer, stability counter and accepted level,
// with combinational rise/fall pulses on the accepting edge.
module gpio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rstN,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], pin_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // The counter only runs while the synchronized pin disagrees with the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            accept   = 1'b1;
            stable_d = sync_q[1];
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign level_o = stable_q;
    assign rise_o  = accept & sync_q[1];
    assign fall_o  = accept & ~sync_q[1];

endmodule

// File: rtl/minized_gpio_inputs.sv
// Conditions PL pushbuttons/switches for the PS GPIO EMIO input bus: debounced levels,
// sticky rise/fall flags cleared by request edges on the EMIO output bus.
module minized_gpio_inputs
    import minized_gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [15:0]      gpio_o,
    output logic [15:0]      gpio_i
);

    logic [WIDTH-1:0]   level, rise, fall;
    logic [WIDTH-1:0]   rise_flag_q, rise_flag_d;
    logic [WIDTH-1:0]   fall_flag_q, fall_flag_d;
    logic [2*WIDTH-1:0] clr_req, clr_q, clr_pulse_q;
    logic               unused_gpio_o;

    for (genvar n = 0; n < WIDTH; n++) begin : gen_lane
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rstN   (rstN),
            .pin_i  (pin_i[n]),
            .level_o(level[n]),
            .rise_o (rise[n]),
            .fall_o (fall[n])
        );
    end

    assign clr_req       = {gpio_o[FALL_LSB +: WIDTH], gpio_o[RISE_LSB +: WIDTH]};
    assign unused_gpio_o = ^gpio_o;

    // The request edge is itself registered, so a clear lands one edge after it is sampled.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            clr_q       <= '0;
            clr_pulse_q <= '0;
            rise_flag_q <= '0;
            fall_flag_q <= '0;
        end else begin
            clr_q       <= clr_req;
            clr_pulse_q <= clr_req & ~clr_q;
            rise_flag_q <= rise_flag_d;
            fall_flag_q <= fall_flag_d;
        end
    end

    // A set arriving with a clear wins so no event is lost.
    always_comb begin
        rise_flag_d = rise | (rise_flag_q & ~clr_pulse_q[WIDTH-1:0]);
        fall_flag_d = fall | (fall_flag_q & ~clr_pulse_q[2*WIDTH-1:WIDTH]);
    end

    always_comb begin
        gpio_i                          = '0;
        gpio_i[LEVEL_LSB +: WIDTH]      = level;
        gpio_i[RISE_LSB +: WIDTH]       = rise_flag_q;
        gpio_i[FALL_LSB +: WIDTH]       = fall_flag_q;
        gpio_i[VERSION_LSB +: 4]        = VERSION;
    end

endmodule

// File: tb/tb_minized_gpio_inputs.sv
// Directed and randomized checks of minized_gpio_inputs against a history-based model.
module tb_minized_gpio_inputs;

    localparam int unsigned D = 8;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  pin_i;
    logic [15:0] gpio_o;
    logic [15:0] gpio_i;

    minized_gpio_inputs #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk   (clk),
        .rstN  (rstN),
        .pin_i (pin_i),
        .gpio_o(gpio_o),
        .gpio_i(gpio_i)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    // Model: accepted level flips once the last D synchronized samples all disagree with it.
    logic [3:0] m_lvl, m_rf, m_ff;
    logic [7:0] m_gprev, m_pend;
    logic [3:0] m_hist[$];

    function automatic logic [15:0] model_out();
        return {4'hA, m_ff, m_rf, m_lvl};
    endfunction

    task automatic model_reset();
        m_lvl = '0; m_rf = '0; m_ff = '0; m_gprev = '0; m_pend = '0;
        m_hist.delete();
        for (int i = 0; i < int'(D) + 2; i++) m_hist.push_back(4'b0000);
    endtask

    task automatic model_edge(input logic [3:0] p, input logic [7:0] g);
        logic [3:0] acc, rise, fall, s;
        logic [7:0] clr;
        m_hist.push_back(p);
        if (m_hist.size() > int'(D) + 4) void'(m_hist.pop_front());
        clr     = m_pend;
        m_pend  = g & ~m_gprev;
        m_gprev = g;
        acc = 4'b1111;
        for (int k = 0; k < int'(D); k++) begin
            s   = m_hist[m_hist.size() - 3 - k];
            acc = acc & (s ^ m_lvl);
        end
        rise  = acc & ~m_lvl;
        fall  = acc & m_lvl;
        m_lvl = m_lvl ^ acc;
        m_rf  = rise | (m_rf & ~clr[3:0]);
        m_ff  = fall | (m_ff & ~clr[7:4]);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n = 1);
        logic [3:0] p;
        logic [7:0] g;
        for (int unsigned i = 0; i < n; i++) begin
            p = pin_i;
            g = gpio_o[11:4];
            @(posedge clk);
            if (rstN) model_edge(p, g);
            #1;
            check("cycle", gpio_i, model_out());
        end
    endtask

    initial begin
        int unsigned hold;
        rstN   = 1'b0;
        pin_i  = '0;
        gpio_o = '0;
        model_reset();

        // Reset
        #2;
        check("reset_hold", gpio_i, 16'hA000);
        step(3);
        #2 rstN = 1'b1;
        step(50);
        check("reset_release", gpio_i, 16'hA000);

        // Clean rise and fall on pin 0
        pin_i[0] = 1'b1;
        step(9);
        check("rise_not_early", {15'b0, gpio_i[0]}, 16'h0000);
        step(1);
        check("rise_exact", gpio_i, 16'hA011);
        pin_i[0] = 1'b0;
        step(9);
        check("fall_not_early", {15'b0, gpio_i[0]}, 16'h0001);
        step(1);
        check("fall_exact", gpio_i, 16'hA110);

        // Glitches on pin 2
        pin_i[2] = 1'b1;
        step(7);
        pin_i[2] = 1'b0;
        step(12);
        check("glitch7", gpio_i, 16'hA110);
        pin_i[2] = 1'b1;
        step(9);
        pin_i[2] = 1'b0;
        step(1);
        check("pulse9", gpio_i, 16'hA154);
        step(12);

        // Clear edge semantics on rise_flag[0]
        gpio_o[4] = 1'b1;
        step(1);
        check("clr_not_early", {15'b0, gpio_i[4]}, 16'h0001);
        step(1);
        check("clr_latency", {15'b0, gpio_i[4]}, 16'h0000);
        pin_i[0] = 1'b1;
        step(10);
        check("held_clr_set", {15'b0, gpio_i[4]}, 16'h0001);
        step(5);
        check("held_clr_stays", {15'b0, gpio_i[4]}, 16'h0001);
        gpio_o = '0;
        step(3);

        // Set/clear collision on lane 1
        pin_i[1] = 1'b1;
        step(8);
        gpio_o[5] = 1'b1;
        step(2);
        check("collision_set_wins", {15'b0, gpio_i[5]}, 16'h0001);
        check("collision_level", {15'b0, gpio_i[1]}, 16'h0001);
        gpio_o = '0;
        step(3);

        // Async reset mid-debounce on pin 3
        pin_i[3] = 1'b1;
        step(7);
        rstN = 1'b0;
        #1;
        check("async_reset", gpio_i, 16'hA000);
        model_reset();
        #1 rstN = 1'b1;
        step(9);
        check("redebounce_not_early", {15'b0, gpio_i[3]}, 16'h0000);
        step(1);
        check("redebounce_done", {15'b0, gpio_i[3]}, 16'h0001);

        // Randomized traffic, alternating busy and quiet pin phases
        for (int unsigned blk = 0; blk < 16; blk++) begin
            hold = (blk % 2 == 0) ? 4 : 24;
            for (int unsigned c = 0; c < 40; c++) begin
                for (int ln = 0; ln < 4; ln++)
                    if ($urandom_range(hold - 1, 0) == 0) pin_i[ln] = ~pin_i[ln];
                if ($urandom_range(3, 0) == 0) gpio_o = 16'($urandom);
                step(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
